// File: rtl/onchip_mem_stream_reader_if.sv
// Bus bundle for onchip_mem_stream_reader: the Avalon-MM read-master pins
// that drive the on-chip memory slave, plus the valid/ready output stream.
// The master modport is the reader's view; slave is the memory + consumer view.
interface onchip_mem_stream_reader_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   m_address;
  logic                m_chipselect;
  logic                m_write;
  logic [DATA_W/8-1:0] m_byteenable;
  logic                m_clken;
  logic [DATA_W-1:0]   m_readdata;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output m_address, m_chipselect, m_write, m_byteenable, m_clken,
    input  m_readdata,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    input  m_address, m_chipselect, m_write, m_byteenable, m_clken,
    output m_readdata,
    input  out_data, out_valid,
    output out_ready
  );
endinterface

// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader: Avalon-MM read master draining a contiguous word
// range from the single-port on-chip memory (fixed 1-cycle read latency) and
// presenting it as a valid/ready stream through a small credit-managed FIFO.
// Optional feature macro: READER_ADDR_WRAP_EN (addresses wrap modulo 2^ADDR_W;
// without it, jobs running past the top of memory are rejected with err).
module onchip_mem_stream_reader #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  output logic                err,
  onchip_mem_stream_reader_if.master bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  // Job registers
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issued_q;
  logic              inflight_q;
  logic              done_zero_q;
  logic              err_q;

  // FIFO
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  // Control decode
  logic issue;
  logic drain_done;
  logic accept;
  logic zero_req;
  logic reject_req;
  logic start_reject;
  logic credit_ok;
  logic push;
  logic pop;

`ifdef READER_ADDR_WRAP_EN
  assign start_reject = 1'b0;
`else
  logic [ADDR_W+1:0] job_end;
  assign job_end      = {2'b00, base_addr} + {1'b0, length};
  assign start_reject = job_end > {2'b01, {ADDR_W{1'b0}}};
`endif

  // Words already buffered plus the read still in the memory pipe must leave
  // room for one more, so every issued read is guaranteed a FIFO slot.
  assign credit_ok = ({1'b0, count_q} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(FIFO_DEPTH);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and per-cycle control decode
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    drain_done = 1'b0;
    accept     = 1'b0;
    zero_req   = 1'b0;
    reject_req = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            zero_req = 1'b1;
          end else if (start_reject) begin
            reject_req = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if ((issued_q < len_q) && credit_ok) begin
          issue = 1'b1;
          if (issued_q + (ADDR_W+1)'(1) == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!inflight_q && (count_q == '0)) begin
          drain_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Job bookkeeping, read pipeline tracking and one-cycle status pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      done_zero_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_zero_q <= zero_req;
      err_q       <= reject_req;
      inflight_q  <= issue;
      if (accept) begin
        base_q   <= base_addr;
        len_q    <= length;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + (ADDR_W+1)'(1);
      end
    end
  end

  assign push = inflight_q;
  assign pop  = bus.out_valid && bus.out_ready;

  // Output FIFO: captures read data one cycle after issue, pops on transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= bus.m_readdata;
        wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // busy drops in the cycle done pulses, so it is cleared by the drain exit
  assign busy = (state_q == S_RUN) || ((state_q == S_DRAIN) && !drain_done);
  assign done = drain_done || done_zero_q;
  assign err  = err_q;

  assign bus.m_address    = base_q + issued_q[ADDR_W-1:0];
  assign bus.m_chipselect = issue;
  assign bus.m_write      = 1'b0;
  assign bus.m_byteenable = '1;
  assign bus.m_clken      = 1'b1;
  assign bus.out_data     = fifo_mem[rd_ptr_q];
  assign bus.out_valid    = (count_q != '0);

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Self-checking bench for onchip_mem_stream_reader. A behavioural memory model
// answers reads with one cycle of latency; expected streams are computed
// directly from the memory array and the job's base/length.
module tb_onchip_mem_stream_reader;
  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 4;
  localparam int MEM_WORDS = 2048;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [10:0] base_addr = '0;
  logic [11:0] length = '0;
  logic        busy, done, err;

  onchip_mem_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  onchip_mem_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Memory slave model
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] rdata = '0;
  always @(posedge clk) if (bus.m_chipselect === 1'b1) rdata <= mem[bus.m_address];
  assign bus.m_readdata = rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  // Consumer ready driver
  int ready_mode  = 0;
  int ready_phase = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: begin
          bus.out_ready = ((ready_phase % 4) == 0) || ((ready_phase % 4) == 3);
          ready_phase++;
        end
        2: bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Observation monitor (sampled mid-cycle)
  logic [31:0] got[$];
  int done_cnt, done_cyc, err_cnt, err_cyc, cs_cnt, busy_cnt;
  int first_busy, last_busy, first_xfer, last_xfer, popped, max_out, stall_viol;
  int write_seen = 0;
  bit prev_stall = 0;
  logic [31:0] prev_data = '0;

  task automatic clear_mon();
    got.delete();
    done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    cs_cnt = 0; busy_cnt = 0; first_busy = -1; last_busy = -1;
    first_xfer = -1; last_xfer = -1; popped = 0; max_out = 0; stall_viol = 0;
  endtask

  always @(negedge clk) begin
    if (bus.m_write !== 1'b0) write_seen++;
    if (bus.m_chipselect === 1'b1) cs_cnt++;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (err === 1'b1) begin err_cnt++; err_cyc = cyc; end
    if (busy === 1'b1) begin
      busy_cnt++;
      if (first_busy < 0) first_busy = cyc;
      last_busy = cyc;
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      got.push_back(bus.out_data);
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
      popped++;
    end
    if (prev_stall && (bus.out_data !== prev_data)) stall_viol++;
    prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
    prev_data  = bus.out_data;
    if (cs_cnt - popped > max_out) max_out = cs_cnt - popped;
  end

  int t_start;

  task automatic start_job(input int b, input int len);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 11'(b); length = 12'(len);
    t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input int b, input int len, output logic [31:0] q[$]);
    q.delete();
    for (int k = 0; k < len; k++) q.push_back(mem[(b + k) % MEM_WORDS]);
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (bus.m_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b want 0", bus.m_chipselect); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.m_address !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.m_address); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", bus.out_data); end
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    n_checks++; if (bus.m_byteenable !== 4'hF || bus.m_clken !== 1'b1) begin
      n_fail++; $display("FAIL tie_offs: got be=%h clken=%b want be=f clken=1", bus.m_byteenable, bus.m_clken);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp[$];
    ready_mode = 0;
    build_exp(16, 8, exp);
    clear_mon();
    start_job(16, 8);
    wait_done(100);
    n_checks++; if (got.size() != 8) begin n_fail++; $display("FAIL basic_count: got %0d want 8", got.size()); end
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      n_checks++; if (got[k] !== exp[k]) begin n_fail++; $display("FAIL basic_word%0d: got %0d want %0d", k, got[k], exp[k]); end
    end
    n_checks++; if (first_xfer != t_start + 3) begin n_fail++; $display("FAIL basic_first_xfer: got %0d want %0d", first_xfer - t_start, 3); end
    n_checks++; if (last_xfer != t_start + 10) begin n_fail++; $display("FAIL basic_last_xfer: got %0d want %0d", last_xfer - t_start, 10); end
    n_checks++; if (done_cyc != t_start + 11) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc - t_start, 11); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (first_busy != t_start + 1) begin n_fail++; $display("FAIL basic_busy_rise: got %0d want 1", first_busy - t_start); end
    n_checks++; if (last_busy != t_start + 10) begin n_fail++; $display("FAIL basic_busy_fall: got %0d want 10", last_busy - t_start); end
    n_checks++; if (write_seen != 0) begin n_fail++; $display("FAIL basic_m_write: got %0d cycles want 0", write_seen); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp[$];
    int b;
    b = $urandom_range(0, 2000);
    build_exp(b, 12, exp);
    clear_mon();
    ready_phase = 0; ready_mode = 1;
    start_job(b, 12);
    wait_done(300);
    n_checks++; if (got.size() != 12) begin n_fail++; $display("FAIL bp_count: got %0d want 12", got.size()); end
    for (int k = 0; k < 12 && k < got.size(); k++) begin
      n_checks++; if (got[k] !== exp[k]) begin n_fail++; $display("FAIL bp_word%0d: got %0d want %0d", k, got[k], exp[k]); end
    end
    n_checks++; if (max_out > DEPTH) begin n_fail++; $display("FAIL bp_occupancy: got %0d want <= %0d", max_out, DEPTH); end
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", stall_viol); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    ready_mode = 0;
  endtask

  task automatic test_zero_length();
    clear_mon();
    start_job(300, 0);
    repeat (6) @(posedge clk); #1;
    n_checks++; if (done_cyc != t_start + 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc - t_start); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (busy_cnt != 0) begin n_fail++; $display("FAIL zero_busy: got %0d cycles want 0", busy_cnt); end
    n_checks++; if (cs_cnt != 0) begin n_fail++; $display("FAIL zero_cs: got %0d cycles want 0", cs_cnt); end
  endtask

  task automatic test_boundary();
    logic [31:0] exp[$];
    int mism;
    clear_mon();
    build_exp(2046, 4, exp);
    start_job(2046, 4);
`ifdef READER_ADDR_WRAP_EN
    wait_done(100);
    n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      n_checks++; if (got[k] !== exp[k]) begin n_fail++; $display("FAIL wrap_word%0d: got %0d want %0d", k, got[k], exp[k]); end
    end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL wrap_err: got %0d want 0", err_cnt); end
`else
    repeat (8) @(posedge clk); #1;
    n_checks++; if (err_cyc != t_start + 1) begin n_fail++; $display("FAIL reject_err_cycle: got %0d want 1", err_cyc - t_start); end
    n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL reject_err_count: got %0d want 1", err_cnt); end
    n_checks++; if (cs_cnt != 0) begin n_fail++; $display("FAIL reject_cs: got %0d want 0", cs_cnt); end
    n_checks++; if (busy_cnt != 0) begin n_fail++; $display("FAIL reject_busy: got %0d want 0", busy_cnt); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL reject_done: got %0d want 0", done_cnt); end
`endif
    // Full-memory job
    clear_mon();
    build_exp(0, MEM_WORDS, exp);
    start_job(0, MEM_WORDS);
    wait_done(2300);
    n_checks++; if (got.size() != MEM_WORDS) begin n_fail++; $display("FAIL full_count: got %0d want %0d", got.size(), MEM_WORDS); end
    mism = 0;
    for (int k = 0; k < got.size() && k < MEM_WORDS; k++) if (got[k] !== exp[k]) mism++;
    n_checks++; if (mism != 0) begin n_fail++; $display("FAIL full_words: got %0d mismatching words want 0", mism); end
    n_checks++; if (done_cyc != t_start + MEM_WORDS + 3) begin n_fail++; $display("FAIL full_done_cycle: got %0d want %0d", done_cyc - t_start, MEM_WORDS + 3); end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL full_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp[$];
    clear_mon();
    ready_mode = 3;
    start_job(100, 8);
    repeat (3) @(posedge clk);
    #3;
    n_checks++; if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: got valid=%b busy=%b want 1 1", bus.out_valid, busy);
    end
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_status: got busy=%b done=%b err=%b want 0 0 0", busy, done, err);
    end
    n_checks++; if (bus.m_chipselect !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_bus: got cs=%b valid=%b want 0 0", bus.m_chipselect, bus.out_valid);
    end
    n_checks++; if (bus.m_address !== '0 || bus.out_data !== '0) begin
      n_fail++; $display("FAIL midreset_values: got addr=%0d data=%0d want 0 0", bus.m_address, bus.out_data);
    end
    @(posedge clk); #2;
    reset_n = 1'b1;
    ready_mode = 0;
    @(posedge clk); #1;
    clear_mon();
    build_exp(5, 2, exp);
    start_job(5, 2);
    wait_done(100);
    n_checks++; if (got.size() != 2) begin n_fail++; $display("FAIL midreset_count: got %0d want 2", got.size()); end
    for (int k = 0; k < 2 && k < got.size(); k++) begin
      n_checks++; if (got[k] !== exp[k]) begin n_fail++; $display("FAIL midreset_word%0d: got %0d want %0d", k, got[k], exp[k]); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL midreset_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] exp[$];
    int mism;
    clear_mon();
    ready_mode = 2;
    build_exp(200, 6, exp);
    start_job(200, 6);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 11'd900; length = 12'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(300);
    repeat (4) @(posedge clk); #1;
    n_checks++; if (got.size() != 6) begin n_fail++; $display("FAIL busy_start_count: got %0d want 6", got.size()); end
    mism = 0;
    for (int k = 0; k < got.size() && k < 6; k++) if (got[k] !== exp[k]) mism++;
    n_checks++; if (mism != 0) begin n_fail++; $display("FAIL busy_start_words: got %0d mismatches want 0", mism); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_start_done: got %0d want 1", done_cnt); end
    ready_mode = 0;
  endtask

  task automatic test_random();
    logic [31:0] exp[$];
    int b, len, mism;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    ready_mode = 2;
    for (int j = 0; j < 6; j++) begin
      len = $urandom_range(1, 40);
`ifdef READER_ADDR_WRAP_EN
      b = $urandom_range(0, MEM_WORDS - 1);
`else
      b = $urandom_range(0, MEM_WORDS - len);
`endif
      clear_mon();
      build_exp(b, len, exp);
      start_job(b, len);
      wait_done(600);
      mism = 0;
      for (int k = 0; k < got.size() && k < len; k++) if (got[k] !== exp[k]) mism++;
      n_checks++; if (got.size() != len || mism != 0) begin
        n_fail++; $display("FAIL rand%0d_words: got %0d words %0d mismatches want %0d words 0 mismatches", j, got.size(), mism, len);
      end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d want 1", j, done_cnt); end
      n_checks++; if (max_out > DEPTH || stall_viol != 0) begin
        n_fail++; $display("FAIL rand%0d_flow: got occupancy %0d stall changes %0d want <=%0d and 0", j, max_out, stall_viol, DEPTH);
      end
      n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL rand%0d_err: got %0d want 0", j, err_cnt); end
    end
    n_checks++; if (write_seen != 0) begin n_fail++; $display("FAIL m_write_total: got %0d cycles want 0", write_seen); end
    ready_mode = 0;
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'(i * 3);
    clear_mon();
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_length();
    test_boundary();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
